// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, RAM req/ack stalls and jump flushes.
// Optional RAM-wait timeout enabled by defining PIPE_HAZARD_CTRL_TIMEOUT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic              id_rs1_use,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs2_use,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_wen,
    input  logic              ex_ram_en,
    input  logic              ex_ram_rw,
    input  logic              ex_j,
    input  logic              ram_ack,
    output logic              ram_req,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              busy,
    output logic              mem_err
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  fcnt_reg, fcnt_next;
    logic        hz;
    logic        timeout;
    logic [1:0]  src_hit;
    logic [REG_AW-1:0] src_addr [2];
    logic [1:0]  src_use;

    assign src_addr[0] = id_rs1_addr;
    assign src_addr[1] = id_rs2_addr;
    assign src_use     = {id_rs2_use, id_rs1_use};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_addr[gi] == ex_rd_addr);
        end
    endgenerate

    // Only a load writing a non-zero register can create a load-use hazard.
    assign hz = ex_ram_en && !ex_ram_rw && ex_wen && (ex_rd_addr != '0) && (|src_hit);

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    logic [7:0] wcnt_reg, wcnt_next;
    logic       mem_err_reg;
`endif

    always_comb begin
        state_next  = state_reg;
        fcnt_next   = fcnt_reg;
        timeout     = 1'b0;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
        wcnt_next   = wcnt_reg;
`endif
        case (state_reg)
            RUN: begin
                if (ex_ram_en && !ram_ack) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                    state_next  = MEM_WAIT;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
                    wcnt_next   = '0;
`endif
                end else if (ex_j) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next = FLUSH;
                        fcnt_next  = 4'(FLUSH_CYCLES - 1);
                    end
                end else if (hz) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (ram_ack) begin
                    state_next = RUN;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
                end else if (wcnt_reg == 8'(TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    state_next = RUN;
`endif
                end else begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
                    wcnt_next   = wcnt_reg + 8'd1;
`endif
                end
            end
            FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                fcnt_next   = fcnt_reg - 4'd1;
                if (fcnt_reg <= 4'd1) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
        // Reset silences every control in the cycle it is asserted.
        if (rst) begin
            pc_stall    = 1'b0;
            if_id_stall = 1'b0;
            if_id_flush = 1'b0;
            id_ex_stall = 1'b0;
            id_ex_flush = 1'b0;
            timeout     = 1'b0;
        end
    end

    assign ram_req = ex_ram_en && (state_reg == RUN || state_reg == MEM_WAIT) && !rst && !timeout;
    assign busy    = (state_reg != RUN) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            fcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
        end
    end

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_reg    <= '0;
            mem_err_reg <= 1'b0;
        end else begin
            wcnt_reg    <= wcnt_next;
            mem_err_reg <= timeout;
        end
    end

    assign mem_err = mem_err_reg && !rst;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int FC     = 3;
    localparam int TO     = 8;
`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, id_rs1_use, id_rs2_use, ex_wen, ex_ram_en, ex_ram_rw, ex_j, ram_ack;
    logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic ram_req, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, busy, mem_err;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Behavioural model state
    bit m_wait      = 1'b0;
    int m_flush_left = 0;
    int m_waited    = 0;
    bit m_err_pend  = 1'b0;

    // Window counters for directed scenarios
    bit win_en = 1'b0;
    int cnt_pcs, cnt_ies, cnt_ief, cnt_iff, cnt_req, cnt_busy, cnt_err;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_CYCLES(FC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs1_use(id_rs1_use),
        .id_rs2_addr(id_rs2_addr), .id_rs2_use(id_rs2_use),
        .ex_rd_addr(ex_rd_addr), .ex_wen(ex_wen),
        .ex_ram_en(ex_ram_en), .ex_ram_rw(ex_ram_rw), .ex_j(ex_j),
        .ram_ack(ram_ack), .ram_req(ram_req),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .busy(busy), .mem_err(mem_err)
    );

    task automatic check_value(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit load_use_hazard();
        logic [REG_AW-1:0] srcs [2];
        bit uses [2];
        bit hit = 1'b0;
        srcs[0] = id_rs1_addr; srcs[1] = id_rs2_addr;
        uses[0] = id_rs1_use;  uses[1] = id_rs2_use;
        for (int k = 0; k < 2; k++)
            if (uses[k] && srcs[k] == ex_rd_addr) hit = 1'b1;
        return ex_ram_en && !ex_ram_rw && ex_wen && ex_rd_addr != 0 && hit;
    endfunction

    // Model evaluation and comparison, mid-cycle while inputs are stable.
    always @(negedge clk) begin
        bit e_req, e_pcs, e_ifs, e_iff, e_ies, e_ief, e_busy, e_err;
        {e_req, e_pcs, e_ifs, e_iff, e_ies, e_ief, e_busy, e_err} = '0;
        if (rst) begin
            m_wait = 0; m_flush_left = 0; m_waited = 0; m_err_pend = 0;
        end else begin
            e_err      = m_err_pend;
            m_err_pend = 0;
            e_busy     = m_wait || (m_flush_left > 0);
            if (m_flush_left > 0) begin
                e_iff = 1; e_ief = 1;
                m_flush_left--;
            end else if (m_wait) begin
                e_req = ex_ram_en;
                if (ram_ack) begin
                    m_wait = 0;
                end else if (TO_EN && m_waited == TO - 1) begin
                    e_req = 0; m_wait = 0; m_err_pend = 1;
                end else begin
                    e_pcs = 1; e_ifs = 1; e_ies = 1;
                    m_waited++;
                end
            end else begin
                e_req = ex_ram_en;
                if (ex_ram_en && !ram_ack) begin
                    e_pcs = 1; e_ifs = 1; e_ies = 1;
                    m_wait = 1; m_waited = 0;
                end else if (ex_j) begin
                    e_iff = 1; e_ief = 1;
                    m_flush_left = FC - 1;
                end else if (load_use_hazard()) begin
                    e_pcs = 1; e_ifs = 1; e_ief = 1;
                end
            end
        end
        check_value("ram_req", int'(ram_req), int'(e_req));
        check_value("pc_stall", int'(pc_stall), int'(e_pcs));
        check_value("if_id_stall", int'(if_id_stall), int'(e_ifs));
        check_value("if_id_flush", int'(if_id_flush), int'(e_iff));
        check_value("id_ex_stall", int'(id_ex_stall), int'(e_ies));
        check_value("id_ex_flush", int'(id_ex_flush), int'(e_ief));
        check_value("busy", int'(busy), int'(e_busy));
        check_value("mem_err", int'(mem_err), int'(e_err));
        if (win_en) begin
            cnt_pcs  += int'(pc_stall);
            cnt_ies  += int'(id_ex_stall);
            cnt_ief  += int'(id_ex_flush);
            cnt_iff  += int'(if_id_flush);
            cnt_req  += int'(ram_req);
            cnt_busy += int'(busy);
            cnt_err  += int'(mem_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; id_rs1_addr = 0; id_rs1_use = 0; id_rs2_addr = 0; id_rs2_use = 0;
        ex_rd_addr = 0; ex_wen = 0; ex_ram_en = 0; ex_ram_rw = 0; ex_j = 0; ram_ack = 0;
    endtask

    task automatic win_start();
        {cnt_pcs, cnt_ies, cnt_ief, cnt_iff, cnt_req, cnt_busy, cnt_err} = '0;
        win_en = 1;
    endtask

    task automatic set_load_use(input logic [REG_AW-1:0] rd);
        ex_ram_en = 1; ex_ram_rw = 0; ex_wen = 1; ex_rd_addr = rd;
        id_rs2_addr = 5; id_rs2_use = 1; ram_ack = 1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) tick();

        // Reset with a pending RAM access
        ex_ram_en = 1;
        win_start();
        repeat (3) tick();
        win_en = 0;
        check_value("rst_req", cnt_req, 0);
        check_value("rst_busy", cnt_busy, 0);
        check_value("rst_stall", cnt_pcs, 0);
        rst = 0; ram_ack = 1;
        win_start(); tick(); win_en = 0;
        check_value("post_rst_req", cnt_req, 1);
        check_value("post_rst_stall", cnt_pcs, 0);
        $display("reset scenario done: req=%0d", cnt_req);

        // Load-use bubble, then rd = x0
        clear_inputs(); tick();
        win_start(); set_load_use(5); tick(); clear_inputs(); tick(); win_en = 0;
        check_value("lu_stall", cnt_pcs, 1);
        check_value("lu_bubble", cnt_ief, 1);
        win_start(); set_load_use(0); tick(); clear_inputs(); tick(); win_en = 0;
        check_value("lu_x0_stall", cnt_pcs, 0);
        $display("load-use scenario done");

        // RAM wait of 4 cycles
        win_start();
        ex_ram_en = 1; ram_ack = 0;
        repeat (4) tick();
        ram_ack = 1; tick();
        clear_inputs(); repeat (2) tick();
        win_en = 0;
        check_value("wait_pc_stall", cnt_pcs, 4);
        check_value("wait_idex_stall", cnt_ies, 4);
        check_value("wait_req", cnt_req, 5);
        check_value("wait_busy", cnt_busy, 4);
        $display("ram-wait scenario done: stall=%0d req=%0d busy=%0d", cnt_pcs, cnt_req, cnt_busy);

        // Jump, then jump together with a load-use hazard
        win_start(); ex_j = 1; tick(); ex_j = 0; repeat (5) tick(); win_en = 0;
        check_value("jump_flush", cnt_iff, FC);
        check_value("jump_idex_flush", cnt_ief, FC);
        win_start(); set_load_use(5); ex_j = 1; tick(); clear_inputs(); repeat (4) tick(); win_en = 0;
        check_value("jump_hz_stall", cnt_pcs, 0);
        check_value("jump_hz_flush", cnt_iff, FC);
        $display("jump scenario done: flush=%0d", cnt_iff);

        // Long RAM wait: timeout or indefinite stall
        if (TO_EN) begin
            win_start(); ex_ram_en = 1; ram_ack = 0; repeat (TO + 1) tick(); win_en = 0;
            check_value("to_stall", cnt_pcs, TO);
            win_start(); tick(); win_en = 0;
            check_value("to_mem_err", cnt_err, 1);
        end else begin
            win_start(); ex_ram_en = 1; ram_ack = 0; repeat (22) tick(); win_en = 0;
            check_value("noto_stall", cnt_pcs, 22);
            check_value("noto_mem_err", cnt_err, 0);
        end
        ram_ack = 1; tick(); clear_inputs(); tick();
        $display("long-wait scenario done: stall=%0d err=%0d", cnt_pcs, cnt_err);

        // Reset during the second MEM_WAIT cycle
        ex_ram_en = 1; ram_ack = 0;
        repeat (2) tick();
        rst = 1; tick();
        clear_inputs();
        win_start(); repeat (3) tick(); win_en = 0;
        check_value("rstmw_stall", cnt_pcs, 0);
        check_value("rstmw_busy", cnt_busy, 0);
        check_value("rstmw_flush", cnt_iff, 0);
        $display("reset-in-wait scenario done");

        // Randomized traffic with varying ack likelihood
        for (int blk = 0; blk < 4; blk++) begin
            int ack_pct;
            ack_pct = (blk == 0) ? 80 : (blk == 1) ? 50 : (blk == 2) ? 20 : 5;
            for (int c = 0; c < 500; c++) begin
                rst         = ($urandom_range(0, 59) == 0);
                ex_ram_en   = ($urandom_range(0, 2) == 0);
                ex_ram_rw   = 1'($urandom_range(0, 1));
                ex_wen      = ($urandom_range(0, 3) != 0);
                ex_rd_addr  = REG_AW'($urandom_range(0, 3));
                id_rs1_addr = REG_AW'($urandom_range(0, 3));
                id_rs2_addr = REG_AW'($urandom_range(0, 3));
                id_rs1_use  = 1'($urandom_range(0, 1));
                id_rs2_use  = 1'($urandom_range(0, 1));
                ex_j        = ($urandom_range(0, 7) == 0);
                ram_ack     = ($urandom_range(0, 99) < ack_pct);
                tick();
            end
            $display("random block %0d (ack %0d%%) done: checks=%0d", blk, ack_pct, chk_cnt);
        end
        clear_inputs();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
